// File: rtl/bcd_updown_counter.sv
// Parametrised multi-digit BCD up/down counter on the 1 Hz tick, with wrap or saturate
// at the limits, a validated parallel load and a terminal-count pulse.
module bcd_updown_counter #(
    parameter int DIGITS  = 2,
    parameter int MOD     = 100,
    parameter int WRAP    = 1,
    parameter int RST_VAL = MOD - 1
) (
    input  logic                  slowclk_1hz,
    input  logic                  RST,
    input  logic                  EN,
    input  logic                  UP,
    input  logic                  LOAD,
    input  logic [4*DIGITS-1:0]   LOAD_VAL,
    output logic [4*DIGITS-1:0]   BCD,
    output logic                  TC,
    output logic                  ERR,
    output logic                  ZERO
);

    localparam int W = 4 * DIGITS;

    function automatic int pow10(input int n);
        int r;
        r = 1;
        for (int i = 0; i < n; i++) r = r * 10;
        return r;
    endfunction

    function automatic logic [W-1:0] to_bcd(input int v);
        logic [W-1:0] r;
        int           t;
        r = '0;
        t = v;
        for (int i = 0; i < DIGITS; i++) begin
            r[4*i +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    function automatic logic [W-1:0] bcd_inc(input logic [W-1:0] v);
        logic [W-1:0] r;
        logic         c;
        r = v;
        c = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (c) begin
                if (r[4*i +: 4] == 4'd9) begin
                    r[4*i +: 4] = 4'd0;
                end else begin
                    r[4*i +: 4] = r[4*i +: 4] + 4'd1;
                    c = 1'b0;
                end
            end
        end
        return r;
    endfunction

    function automatic logic [W-1:0] bcd_dec(input logic [W-1:0] v);
        logic [W-1:0] r;
        logic         b;
        r = v;
        b = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (b) begin
                if (r[4*i +: 4] == 4'd0) begin
                    r[4*i +: 4] = 4'd9;
                end else begin
                    r[4*i +: 4] = r[4*i +: 4] - 4'd1;
                    b = 1'b0;
                end
            end
        end
        return r;
    endfunction

    generate
        if (DIGITS < 1 || DIGITS > 8) begin : g_bad_digits
            $error("bcd_updown_counter: DIGITS must be 1..8");
        end
        if (DIGITS >= 1 && DIGITS <= 8 && (MOD < 2 || MOD > pow10(DIGITS))) begin : g_bad_mod
            $error("bcd_updown_counter: MOD must be 2..10**DIGITS");
        end
        if (RST_VAL < 0 || RST_VAL >= MOD) begin : g_bad_rst
            $error("bcd_updown_counter: RST_VAL must be 0..MOD-1");
        end
        if (WRAP != 0 && WRAP != 1) begin : g_bad_wrap
            $error("bcd_updown_counter: WRAP must be 0 or 1");
        end
    endgenerate

    localparam logic [W-1:0] MAX_BCD = to_bcd(MOD - 1);
    localparam logic [W-1:0] RST_BCD = to_bcd(RST_VAL);

    logic [W-1:0] bcd_q, bcd_d;
    logic         tc_q, tc_d;
    logic         err_q, err_d;
    logic         digits_ok;
    logic         load_ok;
    logic         at_max, at_zero;

    // With every nibble <= 9, plain unsigned compare of packed BCD orders like the decimal value.
    always_comb begin
        digits_ok = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (LOAD_VAL[4*i +: 4] > 4'd9) digits_ok = 1'b0;
        end
        load_ok = digits_ok && (LOAD_VAL <= MAX_BCD);
    end

    assign at_max  = (bcd_q == MAX_BCD);
    assign at_zero = (bcd_q == '0);

    always_comb begin
        bcd_d = bcd_q;
        err_d = err_q;
        tc_d  = 1'b0;
        if (LOAD) begin
            if (load_ok) begin
                bcd_d = LOAD_VAL;
                err_d = 1'b0;
            end else begin
                err_d = 1'b1;
            end
        end else if (EN) begin
            if (UP) begin
                if (at_max) begin
                    tc_d  = 1'b1;
                    bcd_d = (WRAP != 0) ? '0 : bcd_q;
                end else begin
                    bcd_d = bcd_inc(bcd_q);
                end
            end else begin
                if (at_zero) begin
                    tc_d  = 1'b1;
                    bcd_d = (WRAP != 0) ? MAX_BCD : bcd_q;
                end else begin
                    bcd_d = bcd_dec(bcd_q);
                end
            end
        end
    end

    always_ff @(posedge slowclk_1hz or posedge RST) begin
        if (RST) begin
            bcd_q <= RST_BCD;
            tc_q  <= 1'b0;
            err_q <= 1'b0;
        end else begin
            bcd_q <= bcd_d;
            tc_q  <= tc_d;
            err_q <= err_d;
        end
    end

    assign BCD  = bcd_q;
    assign TC   = tc_q;
    assign ERR  = err_q;
    assign ZERO = at_zero;

endmodule

// File: tb/tb_bcd_updown_counter.sv
// Bench for bcd_updown_counter: four configurations share one stimulus stream and are
// checked against an integer reference model, directed vectors and random traffic.
module tb_bcd_updown_counter;

    localparam int NDUT = 4;
    localparam int MODS  [NDUT] = '{100, 60, 100, 1000};
    localparam int WRAPS [NDUT] = '{1, 1, 0, 1};
    localparam int DIGS  [NDUT] = '{2, 2, 2, 3};

    logic        clk;
    logic        rst;
    logic        en;
    logic        up;
    logic        load;
    logic [11:0] load_val;

    logic [7:0]  bcd0, bcd1, bcd2;
    logic [11:0] bcd3;
    logic        tc_a   [NDUT];
    logic        err_a  [NDUT];
    logic        zero_a [NDUT];
    logic [11:0] bcd_a  [NDUT];

    int n_tests;
    int n_fail;

    int m_cnt [NDUT];
    int m_err [NDUT];
    int m_tc  [NDUT];

    bcd_updown_counter #(.DIGITS(2), .MOD(100), .WRAP(1)) u_dut0 (
        .slowclk_1hz(clk), .RST(rst), .EN(en), .UP(up), .LOAD(load), .LOAD_VAL(load_val[7:0]),
        .BCD(bcd0), .TC(tc_a[0]), .ERR(err_a[0]), .ZERO(zero_a[0]));
    bcd_updown_counter #(.DIGITS(2), .MOD(60), .WRAP(1)) u_dut1 (
        .slowclk_1hz(clk), .RST(rst), .EN(en), .UP(up), .LOAD(load), .LOAD_VAL(load_val[7:0]),
        .BCD(bcd1), .TC(tc_a[1]), .ERR(err_a[1]), .ZERO(zero_a[1]));
    bcd_updown_counter #(.DIGITS(2), .MOD(100), .WRAP(0)) u_dut2 (
        .slowclk_1hz(clk), .RST(rst), .EN(en), .UP(up), .LOAD(load), .LOAD_VAL(load_val[7:0]),
        .BCD(bcd2), .TC(tc_a[2]), .ERR(err_a[2]), .ZERO(zero_a[2]));
    bcd_updown_counter #(.DIGITS(3), .MOD(1000), .WRAP(1)) u_dut3 (
        .slowclk_1hz(clk), .RST(rst), .EN(en), .UP(up), .LOAD(load), .LOAD_VAL(load_val),
        .BCD(bcd3), .TC(tc_a[3]), .ERR(err_a[3]), .ZERO(zero_a[3]));

    assign bcd_a[0] = {4'h0, bcd0};
    assign bcd_a[1] = {4'h0, bcd1};
    assign bcd_a[2] = {4'h0, bcd2};
    assign bcd_a[3] = bcd3;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [11:0] dec_to_bcd(input int v);
        return 12'(((v / 100) % 10) * 256 + ((v / 10) % 10) * 16 + (v % 10));
    endfunction

    task automatic check(input string name, input int idx, input logic [31:0] act,
                         input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s dut%0d: got %h, expected %h", name, idx, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NDUT; i++) begin
            m_cnt[i] = MODS[i] - 1;
            m_err[i] = 0;
            m_tc[i]  = 0;
        end
    endtask

    task automatic model_edge(input int i);
        int val, p, nib;
        bit ok;
        m_tc[i] = 0;
        if (load) begin
            ok  = 1;
            val = 0;
            p   = 1;
            for (int d = 0; d < DIGS[i]; d++) begin
                nib = int'(load_val[4*d +: 4]);
                if (nib > 9) ok = 0;
                val += nib * p;
                p   *= 10;
            end
            if (ok && val < MODS[i]) begin
                m_cnt[i] = val;
                m_err[i] = 0;
            end else begin
                m_err[i] = 1;
            end
        end else if (en) begin
            if (up) begin
                if (m_cnt[i] == MODS[i] - 1) begin
                    m_tc[i] = 1;
                    if (WRAPS[i] != 0) m_cnt[i] = 0;
                end else begin
                    m_cnt[i] = m_cnt[i] + 1;
                end
            end else begin
                if (m_cnt[i] == 0) begin
                    m_tc[i] = 1;
                    if (WRAPS[i] != 0) m_cnt[i] = MODS[i] - 1;
                end else begin
                    m_cnt[i] = m_cnt[i] - 1;
                end
            end
        end
    endtask

    task automatic compare_all();
        for (int i = 0; i < NDUT; i++) begin
            check("bcd",  i, 32'(bcd_a[i]),  32'(dec_to_bcd(m_cnt[i])));
            check("tc",   i, 32'(tc_a[i]),   32'(m_tc[i]));
            check("err",  i, 32'(err_a[i]),  32'(m_err[i]));
            check("zero", i, 32'(zero_a[i]), 32'(m_cnt[i] == 0));
        end
    endtask

    task automatic step();
        @(posedge clk);
        for (int i = 0; i < NDUT; i++) model_edge(i);
        #1;
        compare_all();
    endtask

    task automatic async_reset_check();
        rst = 1'b1;
        #1;
        model_reset();
        compare_all();
    endtask

    typedef struct {
        int          dut;
        bit          load;
        bit          en;
        bit          up;
        logic [11:0] lv;
        logic [11:0] bcd;
        bit          tc;
        bit          err;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input int dut, input bit ld, input bit e, input bit u,
                       input logic [11:0] lv, input logic [11:0] b, input bit t, input bit er);
        vec_t v;
        v.dut = dut; v.load = ld; v.en = e; v.up = u; v.lv = lv;
        v.bcd = b; v.tc = t; v.err = er;
        vecs.push_back(v);
    endtask

    initial begin
        int tc_seen, zero_seen, tc_edge;
        n_tests = 0;
        n_fail  = 0;

        // sixty-count wrap, both directions
        add(1, 1, 0, 1, 12'h057, 12'h057, 0, 0);
        add(1, 0, 1, 1, 12'h000, 12'h058, 0, 0);
        add(1, 0, 1, 1, 12'h000, 12'h059, 0, 0);
        add(1, 0, 1, 1, 12'h000, 12'h000, 1, 0);
        add(1, 0, 1, 1, 12'h000, 12'h001, 0, 0);
        add(1, 0, 1, 0, 12'h000, 12'h000, 0, 0);
        add(1, 0, 1, 0, 12'h000, 12'h059, 1, 0);
        // saturate at 99, then turn around
        add(2, 1, 0, 1, 12'h098, 12'h098, 0, 0);
        add(2, 0, 1, 1, 12'h000, 12'h099, 0, 0);
        add(2, 0, 1, 1, 12'h000, 12'h099, 1, 0);
        add(2, 0, 1, 1, 12'h000, 12'h099, 1, 0);
        add(2, 0, 1, 0, 12'h000, 12'h098, 0, 0);
        // invalid loads on the sixty-count instance
        add(1, 1, 0, 0, 12'h030, 12'h030, 0, 0);
        add(1, 1, 0, 0, 12'h09A, 12'h030, 0, 1);
        add(1, 1, 0, 0, 12'h075, 12'h030, 0, 1);
        add(1, 1, 0, 0, 12'h042, 12'h042, 0, 0);
        // load wins over enable
        add(0, 1, 1, 1, 12'h010, 12'h010, 0, 0);
        add(0, 1, 1, 0, 12'h010, 12'h010, 0, 0);
        add(0, 0, 0, 1, 12'h000, 12'h010, 0, 0);
        // three-digit borrow
        add(3, 1, 0, 0, 12'h100, 12'h100, 0, 0);
        add(3, 0, 1, 0, 12'h000, 12'h099, 0, 0);
        add(3, 0, 1, 0, 12'h000, 12'h098, 0, 0);

        rst = 1'b1; en = 1'b0; up = 1'b0; load = 1'b0; load_val = '0;
        model_reset();
        #12;
        compare_all();
        rst = 1'b0;

        // full decrement lap on the default configuration
        en = 1'b1; up = 1'b0;
        tc_seen = 0; zero_seen = 0; tc_edge = -1;
        for (int k = 1; k <= 100; k++) begin
            step();
            if (tc_a[0]) begin tc_seen++; tc_edge = k; end
            if (zero_a[0]) zero_seen++;
        end
        check("lap_tc_count",   0, 32'(tc_seen),   32'd1);
        check("lap_tc_edge",    0, 32'(tc_edge),   32'd100);
        check("lap_zero_count", 0, 32'(zero_seen), 32'd1);
        check("lap_end_bcd",    0, 32'(bcd0),      32'h99);

        foreach (vecs[k]) begin
            load = vecs[k].load; en = vecs[k].en; up = vecs[k].up; load_val = vecs[k].lv;
            step();
            check("vec_bcd", vecs[k].dut, 32'(bcd_a[vecs[k].dut]), 32'(vecs[k].bcd));
            check("vec_tc",  vecs[k].dut, 32'(tc_a[vecs[k].dut]),  32'(vecs[k].tc));
            check("vec_err", vecs[k].dut, 32'(err_a[vecs[k].dut]), 32'(vecs[k].err));
        end

        // set ERR everywhere, then reset mid-cycle and while a load is pending
        load = 1'b1; en = 1'b1; load_val = 12'h0AA;
        step();
        check("pre_rst_err", 3, 32'(err_a[3]), 32'd1);
        #2;
        async_reset_check();
        check("rst_bcd", 3, 32'(bcd3), 32'h999);
        check("rst_err", 3, 32'(err_a[3]), 32'd0);
        load_val = 12'h012;
        @(posedge clk);
        #1;
        compare_all();
        #2;
        rst = 1'b0; load = 1'b0; en = 1'b1; up = 1'b1;
        step();
        check("post_rst_first", 3, 32'(bcd3), 32'h000);

        for (int k = 0; k < 600; k++) begin
            load = ($urandom_range(0, 7) == 0);
            en   = ($urandom_range(0, 3) != 0);
            up   = $urandom_range(0, 1) != 0;
            for (int d = 0; d < 3; d++) load_val[4*d +: 4] = 4'($urandom_range(0, 11));
            if ($urandom_range(0, 5) == 0) load_val[7:0] = 8'h00;
            step();
            if ($urandom_range(0, 99) == 0) begin
                #1;
                async_reset_check();
                #1;
                rst = 1'b0;
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/bcd_updown_counter.md
# bcd_updown_counter

Parametrised multi-digit BCD counter core, clocked by the 1 Hz tick and generalising the fixed mod-100 down counter. Modulus, digit count and wrap/saturate behaviour are set by parameters. Direction, enable and a validated parallel load are runtime controls. Its packed BCD output drives the existing per-digit `display` decoders and the 7-segment scan logic, which run in the fast `slowclk` domain and are outside this block.

## Interface
Parameters:
- `DIGITS`, 2: number of BCD digits; legal range 1–8.
- `MOD`, 100: counting modulus; count range is 0..MOD-1. Legal range is 2 ≤ MOD ≤ 10^DIGITS; any other value is a compile-time error.
- `WRAP`, 1: 1 = wrap at the limits; 0 = saturate (hold) at the limits.
- `RST_VAL`, MOD-1: reset value of the count, as a binary integer; must be < MOD.

Ports:
- `slowclk_1hz`, in, 1: count clock. All state updates on the rising edge.
- `RST`, in, 1: reset, asynchronous, active-high.
- `EN`, in, 1: count enable.
- `UP`, in, 1: direction; 1 = increment, 0 = decrement.
- `LOAD`, in, 1: parallel load request.
- `LOAD_VAL`, in, 4*DIGITS: packed BCD load value; digit 0 (ones) is in [3:0].
- `BCD`, out, 4*DIGITS: packed BCD count, registered; digit 0 is in [3:0].
- `TC`, out, 1: terminal-count pulse, registered.
- `ERR`, out, 1: sticky flag for an invalid load, registered.
- `ZERO`, out, 1: high when `BCD` == 0; decoded combinationally from the `BCD` register.

## Operation
- **Reset.** While `RST`=1: `BCD` = `RST_VAL` encoded as BCD, `TC`=0, `ERR`=0. `ZERO` follows the count (it is 1 only if `RST_VAL`=0).
- **Priority at each edge:** `LOAD` first, then `EN`, then hold.
- **Load (`LOAD`=1):**
  - The load is valid when every nibble of `LOAD_VAL` is ≤ 9 and the decimal value is < MOD.
  - Valid load: `BCD` ← `LOAD_VAL`, `ERR` ← 0, `TC` ← 0.
  - Invalid load: `BCD` unchanged, `ERR` ← 1, `TC` ← 0.
  - `EN` and `UP` are ignored on a load edge.
- **Count (`LOAD`=0, `EN`=1, `UP`=1):**
  - BCD ripple increment. A digit at 9 becomes 0 and carries into the next digit.
  - At MOD-1: with `WRAP`=1 the count goes to 0; with `WRAP`=0 it holds at MOD-1.
- **Count (`LOAD`=0, `EN`=1, `UP`=0):**
  - BCD ripple decrement. A digit at 0 becomes 9 and borrows from the next digit.
  - At 0: with `WRAP`=1 the count goes to MOD-1; with `WRAP`=0 it holds at 0.
- **Terminal event.** A terminal event is an edge where `EN`=1, `LOAD`=0, and the count sits at the limit for the current direction (MOD-1 when `UP`=1, 0 when `UP`=0). `TC` ← 1 on that edge; otherwise `TC` ← 0. `TC` therefore stays high on consecutive edges while held in saturate mode.
- **Hold (`EN`=0, `LOAD`=0):** `BCD` and `ERR` unchanged, `TC` ← 0.
- **Non-decade modulus.** The limit check compares the whole count, not individual digits. For example, with MOD=60, 59 → 00 and 00 → 59.
- **No illegal states.** The count never holds a nibble > 9 or a value ≥ MOD.
- **Direction change.** `UP` may change on any cycle. It takes effect on the next edge; no extra cycle is inserted.

## Timing
- Single clock domain, `slowclk_1hz`. All registered outputs update 1 edge after the qualifying inputs.
- Inputs must be stable around the rising edge of `slowclk_1hz`. Synchronising them is the integrator's job.
- `RST` is asserted asynchronously, so outputs go to their reset values immediately.
- `RST` release is not synchronised inside this block. The first count happens on the first rising edge after release.
- Reset mid-count cancels any pending load or count. `ERR` clears.
- `TC` is high for exactly one period per wrap. It is aligned with the edge on which `BCD` shows the wrapped value.
- No combinational path from inputs to outputs. `ZERO` depends only on `BCD`.

## Test plan
- Defaults (DIGITS=2, MOD=100, WRAP=1); reset, then `EN`=1, `UP`=0 for 100 edges -> `BCD` goes 99, 98 … 00, 99. `TC`=1 only on the edge where 00 → 99. `ZERO`=1 only while the count is 00.
- MOD=60, `UP`=1 from a load of 0x57 -> 58, 59, 00 (`TC`=1), 01. Then `UP`=0 from 00 -> 59 with `TC`=1.
- WRAP=0, `UP`=1 from a load of 0x98 -> 99, 99, 99. `TC` is 0, then 1, then 1. Switching to `UP`=0 gives 98 with `TC`=0.
- Invalid loads: `LOAD_VAL`=0x9A -> `BCD` unchanged, `ERR`=1. Then 0x75 with MOD=60 -> still rejected, `ERR` stays 1. Then 0x42 -> `BCD`=42, `ERR`=0.
- `LOAD`=1 and `EN`=1 on the same edge with `LOAD_VAL`=0x10 -> `BCD`=10, with no count applied.
- DIGITS=3, MOD=1000; load 0x100 and decrement -> 099 (borrow across two digits). Assert `RST` mid-sequence -> `BCD`=999 at once, `TC`=0, `ERR`=0.
